// File: rtl/exotiny_gpo_checker.sv
// exotiny_gpo_checker
//   Self-checking run controller for ExoTiny simulations and FPGA demos.
//   Holds the core in reset for RSTCYCLES cycles after rst_in releases, then
//   counts edges on every GPO channel. It declares PASS once every channel has
//   seen EXPTOGGLES edges, or FAIL when the watchdog expires.
//
//   Ports
//     clk_i        system clock
//     rst_in       asynchronous active-low reset
//     gpo_i        core GPO outputs, synchronous to clk_i
//     sel_i        channel select for cnt_o (out-of-range selects read 0)
//     core_rst_on  active-low reset to the core
//     cnt_o        edge count of the selected channel
//     busy_o       RESET or RUN
//     done_o       PASS or FAIL
//     pass_o       PASS
//     timeout_o    FAIL
//
//   Build option
//     EXOTINY_GPO_STALL_WDT_EN  defined:   the watchdog restarts on any GPO edge
//                                          (stall detector)
//                               undefined: the watchdog counts from RUN entry
//                                          (absolute limit)

// Per-channel edge detector and saturating edge counter.
module exotiny_gpo_chan #(
  parameter int CNTW = 16
) (
  input  logic            clk_i,
  input  logic            rst_in,
  input  logic            en_i,    // count edges (any state but RESET)
  input  logic            gpo_i,
  output logic            edge_o,  // raw edge this cycle, not gated by en_i
  output logic [CNTW-1:0] cnt_o
);
  logic gpo_q;

  assign edge_o = gpo_i ^ gpo_q;

  // gpo_q samples in every state, so entering RUN never sees a stale edge.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      gpo_q <= 1'b0;
      cnt_o <= '0;
    end else begin
      gpo_q <= gpo_i;
      if (en_i && edge_o && (cnt_o != '1)) cnt_o <= cnt_o + CNTW'(1);
    end
  end
endmodule

module exotiny_gpo_checker #(
  parameter int GPOCNT     = 1,
  parameter int RSTCYCLES  = 100,
  parameter int EXPTOGGLES = 8,
  parameter int TIMEOUT    = 100000,
  parameter int CNTW       = 16,
  localparam int SELW      = (GPOCNT > 1) ? $clog2(GPOCNT) : 1
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic [GPOCNT-1:0] gpo_i,
  input  logic [SELW-1:0]   sel_i,
  output logic              core_rst_on,
  output logic [CNTW-1:0]   cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o
);
  localparam int RW = (RSTCYCLES > 1) ? $clog2(RSTCYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_PASS, S_FAIL} state_t;

  state_t                       state, state_nxt;
  logic [RW-1:0]                rcnt;
  logic [WW-1:0]                wcnt;
  logic [GPOCNT-1:0][CNTW-1:0]  cnt;
  logic [GPOCNT-1:0]            edg;
  logic                         cnt_en, pass_cond, wdt_hit, any_edge;

  assign cnt_en   = (state != S_RESET);
  assign any_edge = |edg;
  assign wdt_hit  = (wcnt == WW'(TIMEOUT - 1));

  genvar k;
  generate
    for (k = 0; k < GPOCNT; k++) begin : g_chan
      exotiny_gpo_chan #(.CNTW(CNTW)) u_chan (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .en_i   (cnt_en),
        .gpo_i  (gpo_i[k]),
        .edge_o (edg[k]),
        .cnt_o  (cnt[k])
      );
    end
  endgenerate

  // Pass is judged on registered counts, hence one cycle behind the edge.
  always_comb begin
    pass_cond = 1'b1;
    for (int i = 0; i < GPOCNT; i++)
      if (cnt[i] < CNTW'(EXPTOGGLES)) pass_cond = 1'b0;
  end

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < GPOCNT; i++)
      if (sel_i == SELW'(i)) cnt_o = cnt[i];
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state <= S_RESET;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    core_rst_on = 1'b1;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    pass_o      = 1'b0;
    timeout_o   = 1'b0;
    case (state)
      S_RESET: begin
        core_rst_on = 1'b0;
        busy_o      = 1'b1;
        if (rcnt == RW'(RSTCYCLES - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy_o = 1'b1;
        // pass is checked first so it wins a tie with the watchdog
        if (pass_cond)    state_nxt = S_PASS;
        else if (wdt_hit) state_nxt = S_FAIL;
      end
      S_PASS: begin
        done_o = 1'b1;
        pass_o = 1'b1;
      end
      S_FAIL: begin
        done_o    = 1'b1;
        timeout_o = 1'b1;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // Hold counter runs only in RESET; the watchdog only in RUN, so it is
  // frozen once a verdict is reached.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      rcnt <= '0;
      wcnt <= '0;
    end else begin
      if (state == S_RESET) rcnt <= rcnt + RW'(1);
      if (state == S_RUN) begin
`ifdef EXOTINY_GPO_STALL_WDT_EN
        if (any_edge) wcnt <= '0;
        else          wcnt <= wcnt + WW'(1);
`else
        wcnt <= wcnt + WW'(1);
`endif
      end
    end
  end

`ifndef EXOTINY_GPO_STALL_WDT_EN
  // Edges only restart the watchdog in stall mode.
  logic unused_any_edge;
  assign unused_any_edge = any_edge;
`endif
endmodule

// File: doc/exotiny_gpo_checker.md
# exotiny_gpo_checker

Self-checking run controller for ExoTiny demo and regression simulations. Holds the core in reset for a parametrised number of cycles after the system reset releases. Then counts toggles on each of `GPOCNT` general-purpose outputs and declares pass once every channel reaches the expected toggle count, or fail on a watchdog timeout. It sits between the clock/reset source and `exotiny_sim` and is synthesizable, so the same check can run on FPGA demo boards.

## Interface
- `GPOCNT`, 1: number of monitored GPO channels (≥1).
- `RSTCYCLES`, 100: core reset hold length in `clk_i` cycles (≥1).
- `EXPTOGGLES`, 8: edges required on every channel for pass (≥1, < 2^`CNTW`).
- `TIMEOUT`, 100000: watchdog limit in cycles (≥2).
- `CNTW`, 16: width of each per-channel edge counter.

- `clk_i` in 1: system clock.
- `rst_in` in 1: asynchronous active-low reset; one clock, no other reset.
- `gpo_i` in `GPOCNT`: core GPO outputs, synchronous to `clk_i`.
- `sel_i` in max(1,$clog2(`GPOCNT`)): channel select for `cnt_o`.
- `core_rst_on` out 1: active-low reset to the core.
- `cnt_o` out `CNTW`: edge count of the channel selected by `sel_i`.
- `busy_o` out 1: high in RESET or RUN.
- `done_o` out 1: high in PASS or FAIL.
- `pass_o` out 1: high in PASS.
- `timeout_o` out 1: high in FAIL.

## Operation
- FSM states: RESET, RUN, PASS, FAIL. PASS and FAIL are sticky until `rst_in` is asserted.
- RESET:
  - `core_rst_on`=0.
  - Hold counter `rcnt` increments each cycle.
  - When `rcnt`==`RSTCYCLES`-1, go to RUN.
- RUN:
  - `core_rst_on`=1.
  - Watchdog `wcnt` increments each cycle.
  - For each channel, an edge is `gpo_i[k]` != `gpo_q[k]`, where `gpo_q` is the registered copy of `gpo_i` taken every cycle in all states. Because `gpo_q` is also sampled during RESET, no spurious edge occurs on entering RUN.
  - An edge increments `cnt[k]`. Counters saturate at 2^`CNTW`-1 and never wrap.
- Pass condition: all `cnt[k]` ≥ `EXPTOGGLES`, evaluated on registered counts. Go to PASS.
- Timeout: `wcnt`==`TIMEOUT`-1 and pass condition false. Go to FAIL.
  - If pass condition and timeout hold in the same cycle, PASS wins.
- In PASS and FAIL:
  - `core_rst_on` stays 1, so the core keeps running for waveform inspection.
  - Counters keep counting, saturating.
  - The watchdog freezes.
- `cnt_o` is a combinational mux of `cnt[sel_i]`. If `sel_i` ≥ `GPOCNT`, `cnt_o` = 0.

## Timing
- Reset values on `rst_in`=0 (asynchronous, immediate):
  - state=RESET, `core_rst_on`=0, all counters 0, `gpo_q`=0.
  - `busy_o`=1, `done_o`=`pass_o`=`timeout_o`=0.
- `core_rst_on` rises on the `RSTCYCLES`-th rising `clk_i` edge after `rst_in` deasserts.
- Edge counts:
  - A `gpo_i` change visible before clock edge n is counted in `cnt` after edge n.
  - A channel toggling every cycle counts one edge per cycle.
- Pass latency: `pass_o` rises one cycle after the count that satisfies the pass condition is registered.
- Timeout latency: `timeout_o` rises `TIMEOUT` cycles after RUN entry (absolute mode).
- Reset mid-operation: asserting `rst_in` in any state returns immediately to the reset values above. The full hold sequence then repeats.

## Configuration
- Macro `EXOTINY_GPO_STALL_WDT_EN`.
- Defined: the watchdog works as a stall detector. `wcnt` clears to 0 on any counted edge on any channel, so FAIL means no GPO activity for `TIMEOUT` consecutive cycles.
- Undefined: the watchdog is absolute. `wcnt` never clears in RUN, so FAIL means the pass condition was not met within `TIMEOUT` cycles of RUN entry.

## Test plan
- Reset hold: `RSTCYCLES`=100, `rst_in` released at cycle 0 → `core_rst_on`=0 through cycle 99, 1 from edge 100; `busy_o`=1.
- Pass, multi-channel: `GPOCNT`=2, `EXPTOGGLES`=8; ch0 toggles every 3 cycles, ch1 every 5 cycles → `pass_o` one cycle after ch1's 8th edge; `cnt_o` with `sel_i`=0 ≥ 8.
- Timeout: `TIMEOUT`=1000, ch0 toggles 3 times then stays constant, macro undefined → `timeout_o`=1 exactly 1000 cycles after RUN entry; `pass_o`=0.
- Stall watchdog: macro defined, `TIMEOUT`=50, ch0 toggles every 40 cycles → no FAIL until `EXPTOGGLES` is reached, then PASS. Changing the toggle period to 60 gives FAIL 50 cycles after the first edge.
- Simultaneous events: the 8th edge arrives so that the pass condition holds on the same cycle `wcnt` reaches `TIMEOUT`-1 → PASS, `timeout_o`=0.
- Mid-run reset and saturation:
  - `CNTW`=4 with 20 edges → `cnt_o`=15.
  - Then pulse `rst_in` low for 1 cycle → all outputs return to reset values asynchronously, and the hold restarts.
